// File: rtl/debug_scan_master.sv
// debug_scan_master: host-side virtual-JTAG initiator. Runs one UIR[/CDR/SDR/UDR]
// sequence per command, shifting the DR LSB-first and returning the captured tdo bits.
module debug_scan_master #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2,
  parameter int TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  input  logic                cmd_ir_only,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic [1:0]          rsp_ir,
  output logic                tck,
  output logic                tdi,
  input  logic                tdo,
  output logic [IR_WIDTH-1:0] ir_in,
  input  logic [1:0]          ir_out,
  output logic                vs_uir,
  output logic                vs_cdr,
  output logic                vs_sdr,
  output logic                vs_udr,
  output logic                jtag_state_rti
);

  localparam int HC_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam int BC_W = $clog2(DR_WIDTH + 1);
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(TCK_DIV - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DR_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_UIR  = 3'd1,
    S_CDR  = 3'd2,
    S_SDR  = 3'd3,
    S_UDR  = 3'd4,
    S_RESP = 3'd5
  } state_t;

  state_t              state_r, state_s;
  logic [HC_W-1:0]     half_cnt_r, half_cnt_s;
  logic                phase_r, phase_s;
  logic [BC_W-1:0]     bit_cnt_r, bit_cnt_s;
  logic [DR_WIDTH-1:0] sr_r, sr_s;
  logic                ir_only_r, ir_only_s;
  logic [IR_WIDTH-1:0] ir_in_s;
  logic [1:0]          rsp_ir_s;
  logic [DR_WIDTH-1:0] rsp_dr_s;
  logic                tdi_s;
  logic                scanning_s, half_end_s, rise_s, fall_s;

  // Next-state, tck timebase and shift/capture datapath
  always_comb begin
    state_s    = state_r;
    half_cnt_s = {HC_W{1'b0}};
    phase_s    = 1'b0;
    bit_cnt_s  = bit_cnt_r;
    sr_s       = sr_r;
    ir_only_s  = ir_only_r;
    ir_in_s    = ir_in;
    rsp_ir_s   = rsp_ir;
    rsp_dr_s   = {DR_WIDTH{1'b0}};
    tdi_s      = tdi;
    scanning_s = (state_r == S_UIR) || (state_r == S_CDR) ||
                 (state_r == S_SDR) || (state_r == S_UDR);
    half_end_s = (half_cnt_r == HC_LAST);
    rise_s     = scanning_s && half_end_s && !phase_r;
    fall_s     = scanning_s && half_end_s && phase_r;

    // Timebase idles at the start of a low half so a new scan begins with tck low
    if (!scanning_s) begin
      half_cnt_s = {HC_W{1'b0}};
      phase_s    = 1'b0;
    end else if (half_end_s) begin
      half_cnt_s = {HC_W{1'b0}};
      phase_s    = !phase_r;
    end else begin
      half_cnt_s = half_cnt_r + HC_W'(1);
      phase_s    = phase_r;
    end

    case (state_r)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_s   = S_UIR;
          ir_in_s   = cmd_ir;
          sr_s      = cmd_dr;
          ir_only_s = cmd_ir_only;
          bit_cnt_s = {BC_W{1'b0}};
        end else begin
          state_s = S_IDLE;
        end
      end
      S_UIR: begin
        if (rise_s) begin
          rsp_ir_s = ir_out;
        end else begin
          rsp_ir_s = rsp_ir;
        end
        if (fall_s) begin
          state_s = ir_only_r ? S_RESP : S_CDR;
        end else begin
          state_s = S_UIR;
        end
      end
      S_CDR: begin
        if (fall_s) begin
          state_s   = S_SDR;
          bit_cnt_s = {BC_W{1'b0}};
        end else begin
          state_s = S_CDR;
        end
      end
      S_SDR: begin
        if (rise_s) begin
          sr_s      = {tdo, sr_r[DR_WIDTH-1:1]};
          bit_cnt_s = bit_cnt_r + BC_W'(1);
        end else begin
          sr_s      = sr_r;
          bit_cnt_s = bit_cnt_r;
        end
        if (fall_s) begin
          state_s = (bit_cnt_r == BC_LAST) ? S_UDR : S_SDR;
        end else begin
          state_s = S_SDR;
        end
      end
      S_UDR: begin
        if (fall_s) begin
          state_s = S_RESP;
        end else begin
          state_s = S_UDR;
        end
      end
      S_RESP: begin
        if (rsp_valid && rsp_ready) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_RESP;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase

    // tdi only moves on the tck falling edge, so it is stable across the next rise
    if (fall_s) begin
      tdi_s = (state_s == S_SDR) ? sr_s[0] : 1'b0;
    end else begin
      tdi_s = tdi;
    end

    if ((state_s == S_RESP) && !ir_only_s) begin
      rsp_dr_s = sr_s;
    end else begin
      rsp_dr_s = {DR_WIDTH{1'b0}};
    end
  end

  // State, timebase and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= S_IDLE;
      half_cnt_r     <= {HC_W{1'b0}};
      phase_r        <= 1'b0;
      bit_cnt_r      <= {BC_W{1'b0}};
      sr_r           <= {DR_WIDTH{1'b0}};
      ir_only_r      <= 1'b0;
      ir_in          <= {IR_WIDTH{1'b0}};
      rsp_ir         <= 2'b00;
      rsp_dr         <= {DR_WIDTH{1'b0}};
      rsp_valid      <= 1'b0;
      cmd_ready      <= 1'b1;
      tck            <= 1'b0;
      tdi            <= 1'b0;
      vs_uir         <= 1'b0;
      vs_cdr         <= 1'b0;
      vs_sdr         <= 1'b0;
      vs_udr         <= 1'b0;
      jtag_state_rti <= 1'b1;
    end else begin
      state_r        <= state_s;
      half_cnt_r     <= half_cnt_s;
      phase_r        <= phase_s;
      bit_cnt_r      <= bit_cnt_s;
      sr_r           <= sr_s;
      ir_only_r      <= ir_only_s;
      ir_in          <= ir_in_s;
      rsp_ir         <= rsp_ir_s;
      rsp_dr         <= rsp_dr_s;
      rsp_valid      <= (state_s == S_RESP);
      cmd_ready      <= (state_s == S_IDLE);
      tck            <= phase_s;
      tdi            <= tdi_s;
      vs_uir         <= (state_s == S_UIR);
      vs_cdr         <= (state_s == S_CDR);
      vs_sdr         <= (state_s == S_SDR);
      vs_udr         <= (state_s == S_UDR);
      jtag_state_rti <= (state_s == S_IDLE) || (state_s == S_RESP);
    end
  end

endmodule

// File: tb/tb_debug_scan_master.sv
// Self-checking bench for debug_scan_master: table of scan vectors plus random scans
// against a target model, and hand sequences for hold-off, reset abort and TCK_DIV=1.
module tb_debug_scan_master;

  localparam int DRW = 38;
  localparam int TP  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset, cmd_valid, cmd_ready, cmd_ir_only, rsp_valid, rsp_ready;
  logic           tck, tdi, tdo, vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti;
  logic [1:0]     cmd_ir, rsp_ir, ir_in, ir_out;
  logic [DRW-1:0] cmd_dr, rsp_dr;

  logic       cmd_valid4, cmd_ready4, cmd_ir_only4, rsp_valid4, rsp_ready4;
  logic       tck4, tdi4, tdo4, vs_uir4, vs_cdr4, vs_sdr4, vs_udr4, rti4;
  logic [1:0] cmd_ir4, rsp_ir4, ir_in4, ir_out4;
  logic [3:0] cmd_dr4, rsp_dr4;

  debug_scan_master dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(cmd_ir), .cmd_dr(cmd_dr), .cmd_ir_only(cmd_ir_only),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dr(rsp_dr), .rsp_ir(rsp_ir),
    .tck(tck), .tdi(tdi), .tdo(tdo), .ir_in(ir_in), .ir_out(ir_out),
    .vs_uir(vs_uir), .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_udr(vs_udr),
    .jtag_state_rti(jtag_state_rti)
  );

  debug_scan_master #(.DR_WIDTH(4), .IR_WIDTH(2), .TCK_DIV(1)) dut4 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid4), .cmd_ready(cmd_ready4),
    .cmd_ir(cmd_ir4), .cmd_dr(cmd_dr4), .cmd_ir_only(cmd_ir_only4),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4), .rsp_dr(rsp_dr4), .rsp_ir(rsp_ir4),
    .tck(tck4), .tdi(tdi4), .tdo(tdo4), .ir_in(ir_in4), .ir_out(ir_out4),
    .vs_uir(vs_uir4), .vs_cdr(vs_cdr4), .vs_sdr(vs_sdr4), .vs_udr(vs_udr4),
    .jtag_state_rti(rti4)
  );

  typedef struct {
    logic [1:0]     ir;
    logic [DRW-1:0] dr;
    logic           ir_only;
    logic [1:0]     iro;
    logic           lb;
    logic [DRW-1:0] pat;
    int             hold;
    logic [DRW-1:0] exp_dr;
    logic [1:0]     exp_ir;
    int             exp_lat;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // target model / observer state (owned by the monitor process)
  logic           use_lb = 1'b0;
  logic [DRW-1:0] pat = '0;
  logic           mon_en = 1'b0;
  logic           lb = 1'b0;
  logic           tck_q = 1'b0;
  logic [DRW-1:0] tdi_got = '0;
  logic [7:0]     obs_q = '0;
  int sdr_idx = 0, cnt = 0, rsp_lat = -1;
  int n_uir = 0, n_cdr = 0, n_sdr = 0, n_udr = 0;
  int prev_stage = 0, stage = 0, ord_bad = 0, onehot_bad = 0, edge_bad = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic logic [12:0] idle_vec();
    return {tck, tdi, ir_in, rsp_valid, cmd_ready, jtag_state_rti,
            vs_uir, vs_cdr, vs_sdr, vs_udr, rsp_ir};
  endfunction

  function automatic vec_t mk(input logic [1:0] ir, input logic [DRW-1:0] dr,
                              input logic ir_only, input logic [1:0] iro, input logic lbk,
                              input logic [DRW-1:0] p, input int hold,
                              input logic [DRW-1:0] exp_dr);
    vec_t v;
    v.ir = ir; v.dr = dr; v.ir_only = ir_only; v.iro = iro; v.lb = lbk; v.pat = p;
    v.hold = hold; v.exp_dr = exp_dr; v.exp_ir = iro;
    v.exp_lat = ir_only ? TP : (DRW + 3) * TP;
    return v;
  endfunction

  // Target model and observer: loopback/pattern tdo, TP counts, tdi capture, strobe rules
  always @(negedge clk) begin
    if (cmd_valid && cmd_ready && !reset) begin
      cnt = -1; rsp_lat = -1; sdr_idx = 0; lb = 1'b0; prev_stage = 0; tdi_got = '0;
      n_uir = 0; n_cdr = 0; n_sdr = 0; n_udr = 0;
    end else begin
      cnt++;
      if (rsp_valid && rsp_lat < 0) rsp_lat = cnt;
      if (tck && !tck_q) begin
        if (vs_uir) n_uir++;
        if (vs_cdr) n_cdr++;
        if (vs_udr) n_udr++;
        if (vs_sdr) begin
          n_sdr++;
          if (sdr_idx < DRW) tdi_got[sdr_idx] = tdi;
          sdr_idx++;
        end
        lb = tdi;
      end
      stage = vs_uir ? 1 : vs_cdr ? 2 : vs_sdr ? 3 : vs_udr ? 4 : 0;
      if (mon_en && stage != 0 && stage != prev_stage) begin
        if (stage != prev_stage + 1) ord_bad++;
        prev_stage = stage;
      end
    end
    if (mon_en && $countones({jtag_state_rti, vs_uir, vs_cdr, vs_sdr, vs_udr}) != 1)
      onehot_bad++;
    if (mon_en && tck && ({jtag_state_rti, vs_uir, vs_cdr, vs_sdr, vs_udr, tdi, ir_in} != obs_q))
      edge_bad++;
    obs_q = {jtag_state_rti, vs_uir, vs_cdr, vs_sdr, vs_udr, tdi, ir_in};
    tck_q = tck;
    tdo = use_lb ? lb : pat[(sdr_idx < DRW) ? sdr_idx : 0];
  end

  task automatic run_vec(input vec_t v, input string tag);
    int hold_bad;
    hold_bad = 0;
    cmd_ir = v.ir; cmd_dr = v.dr; cmd_ir_only = v.ir_only; ir_out = v.iro;
    use_lb = v.lb; pat = v.pat; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk({tag, "_accept"}, {62'd0, vs_uir, cmd_ready}, 64'd2);
    for (int i = 0; i < 400 && rsp_lat < 0; i++) @(posedge clk);
    #1;
    chk({tag, "_latency"}, 64'(rsp_lat), 64'(v.exp_lat));
    chk({tag, "_rsp_dr"}, 64'(rsp_dr), 64'(v.exp_dr));
    chk({tag, "_rsp_ir_ir_in"}, {60'd0, rsp_ir, ir_in}, {60'd0, v.exp_ir, v.ir});
    chk({tag, "_tps"}, {32'd0, 8'(n_uir), 8'(n_cdr), 8'(n_sdr), 8'(n_udr)},
        v.ir_only ? {32'd0, 8'd1, 8'd0, 8'd0, 8'd0} : {32'd0, 8'd1, 8'd1, 8'(DRW), 8'd1});
    chk({tag, "_tdi_bits"}, 64'(tdi_got), v.ir_only ? 64'd0 : 64'(v.dr));
    for (int i = 0; i < v.hold; i++) begin
      if (!(rsp_valid === 1'b1 && rsp_dr === v.exp_dr && rsp_ir === v.exp_ir &&
            cmd_ready === 1'b0 && vs_uir === 1'b0)) hold_bad++;
      cmd_valid = i[0];
      cmd_dr = ~cmd_dr;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    if (v.hold > 0) chk({tag, "_hold_stable"}, 64'(hold_bad), 64'd0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, "_ready_back"}, {62'd0, cmd_ready, rsp_valid}, 64'd2);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    vec_t v;
    int aborted_bad;
    int n4, lat4;
    logic [7:0] seq4, exp4;
    logic [3:0] dr4_got;
    logic [1:0] ir4_got;
    logic [3:0] d4;

    reset = 1'b1; cmd_valid = 1'b0; cmd_ir = 2'b00; cmd_dr = '0; cmd_ir_only = 1'b0;
    rsp_ready = 1'b0; ir_out = 2'b00;
    cmd_valid4 = 1'b0; cmd_ir4 = 2'b00; cmd_dr4 = 4'h0; cmd_ir_only4 = 1'b0;
    rsp_ready4 = 1'b1; tdo4 = 1'b1; ir_out4 = 2'b01;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_outputs", 64'(idle_vec()),
        64'({1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 4'b0000, 2'b00}));
    chk("reset_rsp_dr", 64'(rsp_dr), 64'd0);
    chk("reset_dut4", {60'd0, cmd_ready4, rsp_valid4, tck4, rti4}, 64'd9);
    mon_en = 1'b1;
    @(posedge clk); #1;

    tbl.push_back(mk(2'b01, 38'h2A_5A5A_5A5A, 1'b0, 2'b11, 1'b1, '0, 0, 38'h14_B4B4_B4B4));
    tbl.push_back(mk(2'b10, '0, 1'b0, 2'b01, 1'b0, '1, 0, 38'h3F_FFFF_FFFF));
    tbl.push_back(mk(2'b11, 38'h15_5555_5555, 1'b1, 2'b10, 1'b0, '1, 0, '0));
    tbl.push_back(mk(2'b10, 38'h01_2345_6789, 1'b0, 2'b00, 1'b0, 38'h3A_BCDE_F012, 20,
                     38'h3A_BCDE_F012));
    tbl.push_back(mk(2'b01, 38'h20_0000_0001, 1'b1, 2'b01, 1'b0, '0, 0, '0));
    for (int i = 0; i < 6; i++) begin
      v.ir = 2'($urandom_range(0, 3));
      v.dr = DRW'({$urandom, $urandom});
      v.pat = DRW'({$urandom, $urandom});
      v.ir_only = ($urandom_range(0, 3) == 0);
      v.iro = 2'($urandom_range(0, 3));
      tbl.push_back(mk(v.ir, v.dr, v.ir_only, v.iro, 1'b0, v.pat, $urandom_range(0, 3),
                       v.ir_only ? '0 : v.pat));
    end
    foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

    // reset in the middle of SDR aborts the scan without a response
    cmd_ir = 2'b10; cmd_dr = 38'h0F_0F0F_0F0F; cmd_ir_only = 1'b0; use_lb = 1'b0;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 300 && sdr_idx < 10; i++) @(posedge clk);
    chk("abort_reach_bit10", 64'(sdr_idx), 64'd10);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_outputs", 64'(idle_vec()),
        64'({1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 4'b0000, 2'b00}));
    aborted_bad = 0;
    for (int i = 0; i < 200; i++) begin
      if (rsp_valid !== 1'b0 || vs_udr !== 1'b0 || tck !== 1'b0) aborted_bad++;
      @(posedge clk); #1;
    end
    chk("abort_quiet", 64'(aborted_bad), 64'd0);

    // reset wins over a simultaneous command
    reset = 1'b1; cmd_valid = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; cmd_valid = 1'b0;
    chk("reset_vs_cmd", {61'd0, cmd_ready, vs_uir, jtag_state_rti}, 64'd5);
    @(posedge clk); #1;
    chk("reset_vs_cmd_idle", {62'd0, vs_uir, cmd_ready}, 64'd1);
    run_vec(mk(2'b01, 38'h2A_5A5A_5A5A, 1'b0, 2'b10, 1'b1, '0, 0, 38'h14_B4B4_B4B4),
            "post_abort");

    // TCK_DIV=1, DR_WIDTH=4: one tdi bit per two cycles, response at k+14
    for (int r = 0; r < 2; r++) begin
      d4 = (r == 0) ? 4'b1001 : 4'b0011;
      cmd_dr4 = d4; cmd_ir4 = 2'b10; cmd_valid4 = 1'b1;
      @(posedge clk); #1;
      cmd_valid4 = 1'b0;
      chk($sformatf("div1_accept%0d", r), {62'd0, vs_uir4, cmd_ready4}, 64'd2);
      n4 = 0; lat4 = -1; seq4 = 8'h00; dr4_got = 4'h0; ir4_got = 2'b00;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (vs_sdr4) begin
          if (n4 < 8) seq4[n4] = tdi4;
          n4++;
        end
        if (rsp_valid4 && lat4 < 0) begin
          lat4 = c; dr4_got = rsp_dr4; ir4_got = rsp_ir4;
        end
      end
      for (int j = 0; j < 8; j++) exp4[j] = d4[j / 2];
      chk($sformatf("div1_tdi_seq%0d", r), {56'd0, seq4}, {56'd0, exp4});
      chk($sformatf("div1_sdr_cycles%0d", r), 64'(n4), 64'd8);
      chk($sformatf("div1_latency%0d", r), 64'(lat4), 64'd14);
      chk($sformatf("div1_rsp%0d", r), {58'd0, dr4_got, ir4_got}, {58'd0, 4'hF, ir_out4});
      @(posedge clk); #1;
    end

    chk("strobe_onehot", 64'(onehot_bad), 64'd0);
    chk("strobe_order", 64'(ord_bad), 64'd0);
    chk("change_only_tck_low", 64'(edge_bad), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
